// File: rtl/count_ctrl.sv
// -----------------------------------------------------------------------------
// count_ctrl
//   Start/stop/pause controlled 3-bit counter with an optional prescaler.
//   A start pulse begins (or restarts) a run from 0. The count advances on
//   every prescaler tick up to term. It then either finishes (one-shot, done
//   pulse) or wraps back to 0 (continuous, wrap pulse).
//
//   Configuration macro: COUNT_CTRL_PRESCALE_EN
//     defined   : 4-bit prescaler, one tick every div+1 RUN cycles
//     undefined : no prescaler, a tick on every RUN cycle, div is ignored
//
// Ports
//   sysclk  in   clock, all state updates on the rising edge
//   rstn    in   asynchronous active-low reset
//   start   in   one-cycle request to begin or restart a run
//   stop    in   abort the run and return to idle (beats start)
//   pause   in   level: freeze count and prescaler while high
//   mode    in   0 = one-shot, 1 = continuous (sampled every cycle)
//   term    in   [2:0] terminal count value
//   div     in   [3:0] prescale divisor
//   count   out  [2:0] current count, registered
//   busy    out  high in RUN or HOLD
//   done    out  one-cycle pulse on one-shot completion
//   wrap    out  one-cycle pulse when a continuous run wraps term -> 0
// -----------------------------------------------------------------------------
module count_ctrl (
    input  logic       sysclk,
    input  logic       rstn,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       mode,
    input  logic [2:0] term,
    input  logic [3:0] div,
    output logic [2:0] count,
    output logic       busy,
    output logic       done,
    output logic       wrap
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] count_nxt;
    logic       wrap_nxt;
    logic       tick;
    logic       psc_clr;   // clear the prescaler (start / restart / stop)
    logic       psc_run;   // prescaler advances this cycle (unpaused RUN)

`ifdef COUNT_CTRL_PRESCALE_EN
    logic [3:0] psc;

    // The comparison always uses the live div value. If div drops below psc,
    // psc keeps counting and rolls through 15 to 0 without producing a tick.
    assign tick = (psc == div);

    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            psc <= 4'd0;
        end else if (psc_clr) begin
            psc <= 4'd0;
        end else if (psc_run) begin
            psc <= tick ? 4'd0 : psc + 4'd1;
        end
    end
`else
    assign tick = 1'b1;

    // div and the prescaler controls have no consumer in this build.
    logic unused_psc;
    assign unused_psc = ^{div, psc_clr, psc_run};
`endif

    // Next-state logic. Priority in RUN/HOLD is stop > start > pause > tick.
    // IDLE and DONE only react to start.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        count_nxt = count;
        wrap_nxt  = 1'b0;
        psc_clr   = 1'b0;
        psc_run   = 1'b0;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    count_nxt = 3'd0;
                    psc_clr   = 1'b1;
                end else begin
                    // count keeps its value: 0 after stop, term after DONE
                    state_nxt = S_IDLE;
                end
            end

            S_RUN, S_HOLD: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                    count_nxt = 3'd0;
                    psc_clr   = 1'b1;
                end else if (start) begin
                    state_nxt = S_RUN;
                    count_nxt = 3'd0;
                    psc_clr   = 1'b1;
                end else if (pause) begin
                    state_nxt = S_HOLD;
                end else if (state == S_HOLD) begin
                    // resume edge: count and prescaler stay put
                    state_nxt = S_RUN;
                end else begin
                    psc_run = 1'b1;
                    if (tick) begin
                        if (count != term) begin
                            count_nxt = count + 3'd1;
                        end else if (mode) begin
                            count_nxt = 3'd0;
                            wrap_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rstn) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rstn) begin
            state <= S_IDLE;
            count <= 3'd0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // Decoded straight from the state register so reset clears them at once.
    assign busy = (state == S_RUN) || (state == S_HOLD);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_count_ctrl
//   Self-checking bench for count_ctrl: a directed vector table, hand-written
//   multi-cycle sequences, and randomized stimulus compared against a
//   behavioural model of a count run. Inputs change on the falling edge and
//   outputs are compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_count_ctrl;

    logic       sysclk = 1'b0;
    logic       rstn;
    logic       start, stop, pause, mode;
    logic [2:0] term;
    logic [3:0] div;
    logic [2:0] count;
    logic       busy, done, wrap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sysclk = ~sysclk;

    count_ctrl dut (
        .sysclk (sysclk),
        .rstn   (rstn),
        .start  (start),
        .stop   (stop),
        .pause  (pause),
        .mode   (mode),
        .term   (term),
        .div    (div),
        .count  (count),
        .busy   (busy),
        .done   (done),
        .wrap   (wrap)
    );

    // ---------------------------------------------------------------- model
    // A run is described by: is it counting, is it frozen, and which pulse
    // (if any) it produced this cycle. The prescaler is an integer phase.
    bit m_counting, m_frozen, m_done, m_wrap;
    int m_cnt, m_phase;

`ifdef COUNT_CTRL_PRESCALE_EN
    localparam bit PRESCALE = 1'b1;
`else
    localparam bit PRESCALE = 1'b0;
`endif

    function automatic void model_reset();
        m_counting = 0; m_frozen = 0; m_done = 0; m_wrap = 0;
        m_cnt = 0; m_phase = 0;
    endfunction

    function automatic void model_step();
        bit advance;
        m_done = 0;
        m_wrap = 0;
        if (!m_counting && !m_frozen) begin
            if (start) begin
                m_counting = 1; m_cnt = 0; m_phase = 0;
            end
        end else if (stop) begin
            m_counting = 0; m_frozen = 0; m_cnt = 0; m_phase = 0;
        end else if (start) begin
            m_counting = 1; m_frozen = 0; m_cnt = 0; m_phase = 0;
        end else if (pause) begin
            m_counting = 0; m_frozen = 1;
        end else if (m_frozen) begin
            m_frozen = 0; m_counting = 1;
        end else begin
            advance = PRESCALE ? (m_phase == int'(div)) : 1'b1;
            m_phase = advance ? 0 : (m_phase + 1) % 16;
            if (advance) begin
                if (m_cnt != int'(term)) begin
                    m_cnt = (m_cnt + 1) % 8;
                end else if (mode) begin
                    m_cnt = 0; m_wrap = 1;
                end else begin
                    m_counting = 0; m_done = 1;
                end
            end
        end
    endfunction

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int c, input bit b, input bit d, input bit w);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".busy"},  32'(busy),  32'(b));
        check({tag, ".done"},  32'(done),  32'(d));
        check({tag, ".wrap"},  32'(wrap),  32'(w));
    endtask

    // Called at a falling edge: drive inputs, advance the model, then let
    // one rising edge pass and return at the next falling edge.
    task automatic cycle(input bit s, input bit st, input bit p, input bit m,
                         input logic [2:0] t, input logic [3:0] d);
        start = s; stop = st; pause = p; mode = m; term = t; div = d;
        model_step();
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        start = 0; stop = 0; pause = 0; mode = 0; term = 0; div = 0;
        model_reset();
        repeat (2) @(negedge sysclk);
        rstn = 1'b1;
        @(negedge sysclk);
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        bit       start, stop, pause, mode;
        bit [2:0] term;
        bit [3:0] div;
        int       exp_count;
        bit       exp_busy, exp_done, exp_wrap;
    } vec_t;

    vec_t vecs[16];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        // One-shot, term 3: 0,1,2,3 then DONE, then idle holding 3.
        vecs[0]  = '{1,0,0,0,3'd3,4'd0, 0,1,0,0};
        vecs[1]  = '{0,0,0,0,3'd3,4'd0, 1,1,0,0};
        vecs[2]  = '{0,0,0,0,3'd3,4'd0, 2,1,0,0};
        vecs[3]  = '{0,0,0,0,3'd3,4'd0, 3,1,0,0};
        vecs[4]  = '{0,0,0,0,3'd3,4'd0, 3,0,1,0};
        vecs[5]  = '{0,0,0,0,3'd3,4'd0, 3,0,0,0};
        vecs[6]  = '{0,0,1,1,3'd3,4'd0, 3,0,0,0};
        // Continuous, term 2: 0,1,2,0,1,2,0 with wrap on each return to 0.
        vecs[7]  = '{1,0,0,1,3'd2,4'd0, 0,1,0,0};
        vecs[8]  = '{0,0,0,1,3'd2,4'd0, 1,1,0,0};
        vecs[9]  = '{0,0,0,1,3'd2,4'd0, 2,1,0,0};
        vecs[10] = '{0,0,0,1,3'd2,4'd0, 0,1,0,1};
        vecs[11] = '{0,0,0,1,3'd2,4'd0, 1,1,0,0};
        vecs[12] = '{0,0,0,1,3'd2,4'd0, 2,1,0,0};
        vecs[13] = '{0,0,0,1,3'd2,4'd0, 0,1,0,1};
        vecs[14] = '{0,1,0,1,3'd2,4'd0, 0,0,0,0};
        vecs[15] = '{0,0,0,1,3'd2,4'd0, 0,0,0,0};

        // Reset values, sampled while rstn is still low.
        rstn = 1'b0;
        start = 0; stop = 0; pause = 0; mode = 0; term = 0; div = 0;
        model_reset();
        @(negedge sysclk);
        check_outs("reset", 0, 0, 0, 0);
        do_reset();

        foreach (vecs[i]) begin
            cycle(vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].mode,
                  vecs[i].term, vecs[i].div);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_count,
                       vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_wrap);
        end

        // Reset mid-run at count 5: outputs clear without waiting for a clock.
        do_reset();
        cycle(1,0,0,0,3'd7,4'd0);
        for (int i = 1; i <= 5; i++) cycle(0,0,0,0,3'd7,4'd0);
        check("midrst.pre_count", 32'(count), 32'd5);
        #2 rstn = 1'b0;
        model_reset();
        #1 check_outs("midrst.async", 0, 0, 0, 0);
        @(negedge sysclk);
        rstn = 1'b1;
        cycle(0,0,0,0,3'd7,4'd0);
        check_outs("midrst.wait", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(i == 0,0,0,0,3'd7,4'd0);
            check_outs($sformatf("midrst.run%0d", i), i, 1, 0, 0);
        end

        // Pause at count 4 for 5 cycles, resume, then start+stop together.
        do_reset();
        cycle(1,0,0,0,3'd7,4'd0);
        for (int i = 1; i <= 4; i++) cycle(0,0,0,0,3'd7,4'd0);
        check("pause.at4", 32'(count), 32'd4);
        for (int i = 0; i < 5; i++) begin
            cycle(0,0,1,0,3'd7,4'd0);
            check_outs($sformatf("pause.hold%0d", i), 4, 1, 0, 0);
        end
        cycle(0,0,0,0,3'd7,4'd0);
        check_outs("pause.resume", 4, 1, 0, 0);
        cycle(0,0,0,0,3'd7,4'd0);
        check_outs("pause.step", 5, 1, 0, 0);
        cycle(1,1,0,0,3'd7,4'd0);
        check_outs("pause.stopwins", 0, 0, 0, 0);

        // term 0 one-shot: DONE on the first tick, one cycle wide.
        do_reset();
        cycle(1,0,0,0,3'd0,4'd0);
        check_outs("term0.start", 0, 1, 0, 0);
        cycle(0,0,0,0,3'd0,4'd0);
        check_outs("term0.done", 0, 0, 1, 0);
        cycle(0,0,0,0,3'd0,4'd0);
        check_outs("term0.idle", 0, 0, 0, 0);

        // term 0 continuous: wrap on every tick, count stays 0.
        cycle(1,0,0,1,3'd0,4'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(0,0,0,1,3'd0,4'd0);
            check_outs($sformatf("term0c.%0d", i), 0, 1, 0, 1);
        end

`ifdef COUNT_CTRL_PRESCALE_EN
        // div 3, term 1: a step every 4 cycles, done 8 cycles after start.
        do_reset();
        cycle(1,0,0,0,3'd1,4'd3);
        for (int i = 1; i <= 8; i++) begin
            cycle(0,0,0,0,3'd1,4'd3);
            check_outs($sformatf("psc.c%0d", i), (i < 4) ? 0 : 1,
                       i < 8, i == 8, 0);
        end
`endif

        // Randomized run against the model.
        do_reset();
        begin
            bit       r_mode = 0;
            bit [2:0] r_term = 3'd4;
            bit [3:0] r_div  = 4'd1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(31) == 0) r_mode = ~r_mode;
                if ($urandom_range(47) == 0) r_term = 3'($urandom_range(7));
                if ($urandom_range(47) == 0)
                    r_div = ($urandom_range(7) == 0) ? 4'($urandom_range(15))
                                                     : 4'($urandom_range(3));
                cycle($urandom_range(15) == 0, $urandom_range(31) == 0,
                      $urandom_range(7) == 0, r_mode, r_term, r_div);
                check_outs($sformatf("rnd%0d", i), m_cnt,
                           m_counting || m_frozen, m_done, m_wrap);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
